// File: rtl/bomb_countdown_ctrl.sv
// bomb_countdown_ctrl: sequencer for an 8-bit segment driver with a bomb override.
// Runs an armable countdown and shows the current digit as a 7-segment code.
// The digit blinks while count <= BLINK_THRESH. On expiry it asserts the bomb
// override for EXPLODE_TICKS ticks. A defuse request stops the countdown first.
//
// Optional feature: define BOMB_PAUSE_EN to let `pause` freeze an ARMED countdown.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   arm       in   start/restart the countdown (IDLE or DEFUSED)
//   defuse    in   stop an active countdown
//   pause     in   freeze countdown (BOMB_PAUSE_EN builds only)
//   seg_out   out  [7:0] pattern {dp,g,f,e,d,c,b,a}, active-high
//   bomb      out  override to the segment driver (all segments on)
//   state_o   out  [1:0] IDLE=0, ARMED=1, EXPLODE=2, DEFUSED=3
//   count_o   out  [3:0] current digit
//   exploded  out  sticky flag, set on entry to EXPLODE, cleared by arm
module bomb_countdown_ctrl #(
  parameter int TICK_DIV      = 4,
  parameter int START_COUNT   = 9,
  parameter int BLINK_THRESH  = 3,
  parameter int EXPLODE_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm,
  input  logic       defuse,
  input  logic       pause,
  output logic [7:0] seg_out,
  output logic       bomb,
  output logic [1:0] state_o,
  output logic [3:0] count_o,
  output logic       exploded
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (EXPLODE_TICKS > 1) ? $clog2(EXPLODE_TICKS) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_HALF  = PW'(TICK_DIV / 2);
  localparam logic [HW-1:0] HOLD_LAST = HW'(EXPLODE_TICKS - 1);
  localparam logic [3:0]    START     = 4'(START_COUNT);
  localparam logic [3:0]    THRESH    = 4'(BLINK_THRESH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    EXPLODE = 2'd2,
    DEFUSED = 2'd3
  } state_t;

  state_t        state, ns;
  logic [3:0]    count, nc;
  logic [PW-1:0] presc, np;
  logic [HW-1:0] hold, nh;
  logic [7:0]    seg_next;
  logic          expl_next;
  logic          tick;
  logic          paused;
  logic          steady;

`ifdef BOMB_PAUSE_EN
  assign paused = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign paused       = 1'b0;
`endif

  function automatic logic [7:0] digit(input logic [3:0] d);
    case (d)
      4'd0:    digit = 8'h3F;
      4'd1:    digit = 8'h06;
      4'd2:    digit = 8'h5B;
      4'd3:    digit = 8'h4F;
      4'd4:    digit = 8'h66;
      4'd5:    digit = 8'h6D;
      4'd6:    digit = 8'h7D;
      4'd7:    digit = 8'h07;
      4'd8:    digit = 8'h7F;
      4'd9:    digit = 8'h6F;
      default: digit = 8'h00;
    endcase
  endfunction

  assign tick = (presc == PRE_LAST);

  // Next-state values; outputs are registered from these so that an event
  // sampled at an edge is already reflected on the outputs after that edge.
  always_comb begin
    ns     = state;
    nc     = count;
    np     = presc;
    nh     = hold;
    steady = 1'b0;
    case (state)
      IDLE: begin
        if (arm) begin
          ns = ARMED;
          nc = START;
          np = '0;
        end
      end
      ARMED: begin
        if (defuse) begin
          // defuse wins over a same-cycle tick, including the final one
          ns = DEFUSED;
          np = '0;
        end else if (paused) begin
          steady = 1'b1;
        end else if (tick) begin
          np = '0;
          if (count == 4'd0) begin
            ns = EXPLODE;
            nh = '0;
          end else begin
            nc = count - 4'd1;
          end
        end else begin
          np = presc + 1'b1;
        end
      end
      EXPLODE: begin
        if (tick) begin
          np = '0;
          if (hold == HOLD_LAST) ns = IDLE;
          else                   nh = hold + 1'b1;
        end else begin
          np = presc + 1'b1;
        end
      end
      DEFUSED: begin
        if (arm) begin
          ns = ARMED;
          nc = START;
          np = '0;
        end
      end
      default: ns = IDLE;
    endcase
  end

  always_comb begin
    seg_next = 8'h00;
    case (ns)
      ARMED: begin
        // blank during the second half of each tick once in the final counts
        if (nc <= THRESH && np >= PRE_HALF && !steady) seg_next = 8'h00;
        else                                           seg_next = digit(nc);
      end
      DEFUSED: seg_next = digit(nc) | 8'h80;
      default: seg_next = 8'h00;
    endcase

    expl_next = exploded;
    if (ns == EXPLODE)                       expl_next = 1'b1;
    else if (ns == ARMED && state != ARMED)  expl_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      presc    <= '0;
      hold     <= '0;
      seg_out  <= '0;
      bomb     <= 1'b0;
      exploded <= 1'b0;
    end else begin
      state    <= ns;
      count    <= nc;
      presc    <= np;
      hold     <= nh;
      seg_out  <= seg_next;
      bomb     <= (ns == EXPLODE);
      exploded <= expl_next;
    end
  end

  assign state_o = state;
  assign count_o = count;

endmodule

// File: tb/tb_bomb_countdown_ctrl.sv
module tb_bomb_countdown_ctrl;

  logic       clk;
  logic       rst_n;
  logic       arm;
  logic       defuse;
  logic       pause;
  logic [7:0] seg_out;
  logic       bomb;
  logic [1:0] state_o;
  logic [3:0] count_o;
  logic       exploded;

  int checks = 0;
  int errors = 0;

  bomb_countdown_ctrl #(
    .TICK_DIV      (4),
    .START_COUNT   (9),
    .BLINK_THRESH  (3),
    .EXPLODE_TICKS (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .arm      (arm),
    .defuse   (defuse),
    .pause    (pause),
    .seg_out  (seg_out),
    .bomb     (bomb),
    .state_o  (state_o),
    .count_o  (count_o),
    .exploded (exploded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] dig [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                           8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  typedef struct {
    string      name;
    logic       rst_n;
    logic       arm;
    logic       defuse;
    logic [1:0] st;
    logic [3:0] cnt;
    logic [7:0] seg;
    logic       bomb;
    logic       expl;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [1:0] st, input logic [3:0] cnt,
                            input logic [7:0] seg, input logic bomb_e, input logic expl_e);
    checks++;
    if ({state_o, count_o, seg_out, bomb, exploded} !== {st, cnt, seg, bomb_e, expl_e}) begin
      errors++;
      $display("FAIL %s: got st=%0d cnt=%0d seg=%02h bomb=%0b expl=%0b, expected st=%0d cnt=%0d seg=%02h bomb=%0b expl=%0b",
               name, state_o, count_o, seg_out, bomb, exploded, st, cnt, seg, bomb_e, expl_e);
    end
  endtask

  // visible pattern for count c, prescaler phase p (defaults: thresh 3, half 2)
  function automatic logic [7:0] seg_for(input int c, input int p);
    if (c <= 3 && p >= 2) return 8'h00;
    return dig[c];
  endfunction

  initial begin
    rst_n  = 1'b0;
    arm    = 1'b0;
    defuse = 1'b0;
    pause  = 1'b0;

    vecs.push_back(vec_t'{"reset",        1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 8'h00, 1'b0, 1'b0});
    vecs.push_back(vec_t'{"idle",         1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 8'h00, 1'b0, 1'b0});
    vecs.push_back(vec_t'{"idle_defuse",  1'b1, 1'b0, 1'b1, 2'd0, 4'd0, 8'h00, 1'b0, 1'b0});
    vecs.push_back(vec_t'{"arm",          1'b1, 1'b1, 1'b0, 2'd1, 4'd9, 8'h6F, 1'b0, 1'b0});
    vecs.push_back(vec_t'{"nine_p1",      1'b1, 1'b0, 1'b0, 2'd1, 4'd9, 8'h6F, 1'b0, 1'b0});
    vecs.push_back(vec_t'{"nine_p2",      1'b1, 1'b0, 1'b0, 2'd1, 4'd9, 8'h6F, 1'b0, 1'b0});
    vecs.push_back(vec_t'{"nine_p3",      1'b1, 1'b0, 1'b0, 2'd1, 4'd9, 8'h6F, 1'b0, 1'b0});
    vecs.push_back(vec_t'{"eight",        1'b1, 1'b0, 1'b0, 2'd1, 4'd8, 8'h7F, 1'b0, 1'b0});
    vecs.push_back(vec_t'{"armed_arm",    1'b1, 1'b1, 1'b0, 2'd1, 4'd8, 8'h7F, 1'b0, 1'b0});
    vecs.push_back(vec_t'{"eight_p2",     1'b1, 1'b0, 1'b0, 2'd1, 4'd8, 8'h7F, 1'b0, 1'b0});
    vecs.push_back(vec_t'{"eight_p3",     1'b1, 1'b0, 1'b0, 2'd1, 4'd8, 8'h7F, 1'b0, 1'b0});
    vecs.push_back(vec_t'{"seven",        1'b1, 1'b0, 1'b0, 2'd1, 4'd7, 8'h07, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      rst_n  = vecs[i].rst_n;
      arm    = vecs[i].arm;
      defuse = vecs[i].defuse;
      step();
      expect_out(vecs[i].name, vecs[i].st, vecs[i].cnt, vecs[i].seg, vecs[i].bomb, vecs[i].expl);
    end
    arm    = 1'b0;
    defuse = 1'b0;

    // countdown 7..0 with blinking in the final counts, then expiry
    for (int d = 7; d >= 0; d--) begin
      for (int p = 1; p < 4; p++) begin
        step();
        expect_out("countdown", 2'd1, 4'(d), seg_for(d, p), 1'b0, 1'b0);
      end
      step();
      if (d > 0) expect_out("digit_step", 2'd1, 4'(d - 1), seg_for(d - 1, 0), 1'b0, 1'b0);
    end
    expect_out("explode_entry", 2'd2, 4'd0, 8'h00, 1'b1, 1'b1);
    for (int i = 1; i < 16; i++) begin
      step();
      expect_out("explode_hold", 2'd2, 4'd0, 8'h00, 1'b1, 1'b1);
    end
    step();
    expect_out("explode_done", 2'd0, 4'd0, 8'h00, 1'b0, 1'b1);

    // defuse at count 5, then re-arm
    arm = 1'b1;
    step();
    arm = 1'b0;
    expect_out("rearm_idle", 2'd1, 4'd9, 8'h6F, 1'b0, 1'b0);
    repeat (16) step();
    expect_out("at_five", 2'd1, 4'd5, 8'h6D, 1'b0, 1'b0);
    defuse = 1'b1;
    step();
    defuse = 1'b0;
    expect_out("defuse_five", 2'd3, 4'd5, 8'hED, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      expect_out("defused_stays", 2'd3, 4'd5, 8'hED, 1'b0, 1'b0);
    end
    arm = 1'b1;
    step();
    arm = 1'b0;
    expect_out("rearm_defused", 2'd1, 4'd9, 8'h6F, 1'b0, 1'b0);

    // defuse coinciding with the final tick at count 0
    repeat (39) step();
    expect_out("zero_p3", 2'd1, 4'd0, 8'h00, 1'b0, 1'b0);
    defuse = 1'b1;
    step();
    defuse = 1'b0;
    expect_out("defuse_zero_tick", 2'd3, 4'd0, 8'hBF, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      expect_out("no_bomb_after_defuse", 2'd3, 4'd0, 8'hBF, 1'b0, 1'b0);
    end

    // reset in the middle of an explosion
    arm = 1'b1;
    step();
    arm = 1'b0;
    expect_out("rearm_for_reset", 2'd1, 4'd9, 8'h6F, 1'b0, 1'b0);
    repeat (40) step();
    expect_out("explode_again", 2'd2, 4'd0, 8'h00, 1'b1, 1'b1);
    repeat (2) step();
    rst_n = 1'b0;
    step();
    expect_out("reset_in_explode", 2'd0, 4'd0, 8'h00, 1'b0, 1'b0);
    rst_n  = 1'b1;
    step();
    expect_out("post_reset_idle", 2'd0, 4'd0, 8'h00, 1'b0, 1'b0);
    arm    = 1'b1;
    defuse = 1'b1;
    step();
    arm    = 1'b0;
    defuse = 1'b0;
    expect_out("arm_defuse_idle", 2'd1, 4'd9, 8'h6F, 1'b0, 1'b0);

    // pause held for 10 cycles at count 7
    repeat (8) step();
    expect_out("pause_start", 2'd1, 4'd7, 8'h07, 1'b0, 1'b0);
    pause = 1'b1;
`ifdef BOMB_PAUSE_EN
    for (int i = 1; i <= 10; i++) begin
      step();
      expect_out("paused", 2'd1, 4'd7, 8'h07, 1'b0, 1'b0);
    end
    pause = 1'b0;
    repeat (3) begin
      step();
      expect_out("resume_hold", 2'd1, 4'd7, 8'h07, 1'b0, 1'b0);
    end
    step();
    expect_out("resume_step", 2'd1, 4'd6, 8'h7D, 1'b0, 1'b0);
`else
    for (int i = 1; i <= 10; i++) begin
      step();
      expect_out("pause_ignored", 2'd1, 4'(7 - i / 4), dig[7 - i / 4], 1'b0, 1'b0);
    end
    pause = 1'b0;
    step();
    expect_out("after_pause_p3", 2'd1, 4'd5, 8'h6D, 1'b0, 1'b0);
    step();
    expect_out("after_pause_step", 2'd1, 4'd4, 8'h66, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
